// File: rtl/fetch_stage_if.sv
// Instruction-memory port 1 bundle between the fetch stage and instruction memory.
// The fetch stage is the master: it issues the read request and address, and
// memory answers with data and an acknowledge.
interface fetch_stage_if #(
  parameter int WORD_SIZE = 16
);
  logic                 readM1;
  logic [WORD_SIZE-1:0] address1;
  logic [WORD_SIZE-1:0] data1;
  logic                 inputReady1;

  modport master (
    output readM1,
    output address1,
    input  data1,
    input  inputReady1
  );

  modport slave (
    input  readM1,
    input  address1,
    output data1,
    output inputReady1
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, drives instruction memory
// port 1 and fills the IF/ID pipeline register. A one-entry skid buffer catches
// an instruction acknowledged while decode is stalled. Redirects and halt wait
// out any in-flight memory request (DRAIN / HALT_DRAIN) so memory always sees a
// stable address until it acknowledges.
module fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] NOP_WORD  = 16'hF01C
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fetch_stage_if.master        mem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] IF_ID_ins,
  output logic [WORD_SIZE-1:0] IF_ID_nextPC,
  output logic                 IF_ID_valid,
  output logic [WORD_SIZE-1:0] PC,
  output logic                 is_halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN,
    S_HALT_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  state_t               state, state_nx;
  logic [WORD_SIZE-1:0] pc_nx;
  logic [WORD_SIZE-1:0] held_addr, held_addr_nx;
  logic [WORD_SIZE-1:0] buf_ins, buf_ins_nx;
  logic [WORD_SIZE-1:0] buf_npc, buf_npc_nx;
  logic                 buf_valid, buf_valid_nx;
  logic [WORD_SIZE-1:0] if_ins_nx, if_npc_nx;
  logic                 if_valid_nx;
  logic [WORD_SIZE-1:0] pc_plus1;
  logic                 ack;
  logic                 pending_unacked;

  assign pc_plus1        = PC + ONE;
  assign ack             = mem.readM1 & mem.inputReady1;
  assign pending_unacked = mem.readM1 & ~mem.inputReady1;

  // Memory request decode: fetch from PC unless the skid buffer is full; the drain states keep the abandoned request's address on the bus.
  always_comb begin
    mem.readM1   = 1'b0;
    mem.address1 = PC;
    case (state)
      S_FETCH: begin
        mem.readM1   = ~buf_valid;
        mem.address1 = PC;
      end
      S_DRAIN, S_HALT_DRAIN: begin
        mem.readM1   = 1'b1;
        mem.address1 = held_addr;
      end
      default: begin
        mem.readM1   = 1'b0;
        mem.address1 = PC;
      end
    endcase
  end

  // Next-state logic; priority within a cycle is redirect, then halt, then stall, then normal flow.
  always_comb begin
    state_nx     = state;
    pc_nx        = PC;
    held_addr_nx = held_addr;
    buf_ins_nx   = buf_ins;
    buf_npc_nx   = buf_npc;
    buf_valid_nx = buf_valid;
    if_ins_nx    = IF_ID_ins;
    if_npc_nx    = IF_ID_nextPC;
    if_valid_nx  = IF_ID_valid;

    case (state)
      S_FETCH: begin
        if (redirect) begin
          if_ins_nx    = NOP_WORD;
          if_npc_nx    = '0;
          if_valid_nx  = 1'b0;
          buf_valid_nx = 1'b0;
          pc_nx        = redirect_pc;
          if (pending_unacked) begin
            state_nx     = S_DRAIN;
            held_addr_nx = PC;
          end
        end else if (halt) begin
          if_ins_nx    = NOP_WORD;
          if_npc_nx    = '0;
          if_valid_nx  = 1'b0;
          buf_valid_nx = 1'b0;
          if (pending_unacked) begin
            state_nx     = S_HALT_DRAIN;
            held_addr_nx = PC;
          end else begin
            state_nx = S_HALTED;
          end
        end else begin
          if (ack) begin
            pc_nx = pc_plus1;
          end
          if (stall) begin
            if (ack) begin
              buf_ins_nx   = mem.data1;
              buf_npc_nx   = pc_plus1;
              buf_valid_nx = 1'b1;
            end
          end else if (buf_valid) begin
            if_ins_nx    = buf_ins;
            if_npc_nx    = buf_npc;
            if_valid_nx  = 1'b1;
            buf_valid_nx = 1'b0;
          end else if (ack) begin
            if_ins_nx   = mem.data1;
            if_npc_nx   = pc_plus1;
            if_valid_nx = 1'b1;
          end else begin
            if_ins_nx   = NOP_WORD;
            if_valid_nx = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if_ins_nx   = NOP_WORD;
        if_npc_nx   = '0;
        if_valid_nx = 1'b0;
        if (redirect) begin
          pc_nx = redirect_pc;
          if (ack) begin
            state_nx = S_FETCH;
          end
        end else if (halt) begin
          state_nx = ack ? S_HALTED : S_HALT_DRAIN;
        end else if (ack) begin
          state_nx = S_FETCH;
        end
      end

      S_HALT_DRAIN: begin
        if_ins_nx   = NOP_WORD;
        if_npc_nx   = '0;
        if_valid_nx = 1'b0;
        if (ack) begin
          state_nx = S_HALTED;
        end
      end

      default: begin
        if_ins_nx   = NOP_WORD;
        if_npc_nx   = '0;
        if_valid_nx = 1'b0;
      end
    endcase
  end

  // State, PC, skid buffer and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state        <= S_FETCH;
      PC           <= RESET_PC;
      held_addr    <= RESET_PC;
      buf_ins      <= NOP_WORD;
      buf_npc      <= '0;
      buf_valid    <= 1'b0;
      IF_ID_ins    <= NOP_WORD;
      IF_ID_nextPC <= '0;
      IF_ID_valid  <= 1'b0;
      is_halted    <= 1'b0;
    end else begin
      state        <= state_nx;
      PC           <= pc_nx;
      held_addr    <= held_addr_nx;
      buf_ins      <= buf_ins_nx;
      buf_npc      <= buf_npc_nx;
      buf_valid    <= buf_valid_nx;
      IF_ID_ins    <= if_ins_nx;
      IF_ID_nextPC <= if_npc_nx;
      IF_ID_valid  <= if_valid_nx;
      is_halted    <= (state_nx == S_HALTED);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: variable-latency instruction memory model plus a
// program-order scoreboard. The scoreboard only knows the architectural rules:
// decode consumes a valid IF/ID entry whenever it is not stalling, consecutive
// consumed instructions come from consecutive addresses, and a redirect
// restarts the expected stream at its target.
module tb_fetch_stage;
  localparam int          W        = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'hF01C;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] IF_ID_ins;
  logic [15:0] IF_ID_nextPC;
  logic        IF_ID_valid;
  logic [15:0] PC;
  logic        is_halted;

  int checks;
  int failures;

  fetch_stage_if #(.WORD_SIZE(W)) mem_if ();

  fetch_stage #(
    .WORD_SIZE(W),
    .RESET_PC (RESET_PC),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem         (mem_if),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .IF_ID_ins   (IF_ID_ins),
    .IF_ID_nextPC(IF_ID_nextPC),
    .IF_ID_valid (IF_ID_valid),
    .PC          (PC),
    .is_halted   (is_halted)
  );

  wire        rd   = mem_if.readM1;
  wire [15:0] addr = mem_if.address1;
  wire        rdy  = mem_if.inputReady1;

  // Memory contents: a fixed bijection of the address so every word is distinct.
  function automatic logic [15:0] mw(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acknowledges a request after cur_lat waiting cycles, picking a fresh latency per request.
  int lat_min;
  int lat_max;
  int cur_lat;
  int wait_cnt;

  always @(posedge clk) begin
    if (reset_n) begin
      wait_cnt <= 0;
      cur_lat  <= lat_min;
    end else if (rd && rdy) begin
      wait_cnt <= 0;
      cur_lat  <= int'($urandom_range(lat_max, lat_min));
    end else if (rd) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  assign mem_if.inputReady1 = rd && (wait_cnt >= cur_lat);
  assign mem_if.data1       = mem_if.inputReady1 ? mw(mem_if.address1) : 16'hDEAD;

  // Reference model state.
  logic [15:0] exp_pc;
  logic [15:0] exp_next;
  bit          model_halted;
  bit          prev_pending;
  logic [15:0] prev_addr;
  int          delivered;

  // Advance one cycle: evaluate the model just before the rising edge, then return at the next falling edge.
  task automatic step();
    #4;
    if (reset_n) begin
      exp_pc       = RESET_PC;
      model_halted = 1'b0;
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        checks++;
        if ({rd, addr} !== {1'b1, prev_addr}) begin
          failures++;
          $display("[TB] FAIL addr_hold: got rd=%b addr=%h expected rd=1 addr=%h", rd, addr, prev_addr);
        end
      end
      prev_pending = rd && !rdy;
      prev_addr    = addr;
      if (!model_halted && redirect) begin
        exp_pc = redirect_pc;
      end else if (!model_halted && halt) begin
        model_halted = 1'b1;
      end else if (model_halted) begin
        checks++;
        if (IF_ID_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL halted_valid: got %b expected 0", IF_ID_valid);
        end
      end else if (IF_ID_valid === 1'b1 && !stall) begin
        exp_next = exp_pc + 16'd1;
        checks++;
        if ({IF_ID_ins, IF_ID_nextPC} !== {mw(exp_pc), exp_next}) begin
          failures++;
          $display("[TB] FAIL stream: got ins=%h npc=%h expected ins=%h npc=%h", IF_ID_ins, IF_ID_nextPC, mw(exp_pc), exp_next);
        end
        exp_pc = exp_next;
        delivered++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n     = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    halt        = 1'b0;
    redirect_pc = '0;
    step();
    step();
    reset_n = 1'b0;
  endtask

  task automatic test_reset();
    lat_min = 3;
    lat_max = 3;
    do_reset();
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if ({PC, IF_ID_ins, IF_ID_nextPC, IF_ID_valid, is_halted} !== {RESET_PC, NOP, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h expected %h", {PC, IF_ID_ins, IF_ID_nextPC, IF_ID_valid, is_halted}, {RESET_PC, NOP, 16'h0000, 1'b0, 1'b0});
    end
    checks++;
    if ({rd, addr} !== {1'b1, RESET_PC}) begin
      failures++;
      $display("[TB] FAIL reset_fetch: got rd=%b addr=%h expected rd=1 addr=%h", rd, addr, RESET_PC);
    end
    reset_n = 1'b0;
  endtask

  task automatic test_single_cycle();
    lat_min = 0;
    lat_max = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({IF_ID_ins, IF_ID_nextPC, IF_ID_valid, PC} !== {mw(16'(i)), 16'(i + 1), 1'b1, 16'(i + 1)}) begin
        failures++;
        $display("[TB] FAIL single_cycle_%0d: got ins=%h npc=%h v=%b pc=%h expected ins=%h npc=%h v=1 pc=%h", i, IF_ID_ins, IF_ID_nextPC, IF_ID_valid, PC, mw(16'(i)), 16'(i + 1), 16'(i + 1));
      end
    end
  endtask

  task automatic test_latency();
    lat_min = 2;
    lat_max = 2;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rd, addr, IF_ID_valid, rdy} !== {1'b1, 16'h0000, 1'b0, (k == 2)}) begin
        failures++;
        $display("[TB] FAIL latency_wait_%0d: got rd=%b addr=%h v=%b rdy=%b expected rd=1 addr=0000 v=0 rdy=%b", k, rd, addr, IF_ID_valid, rdy, (k == 2));
      end
      step();
    end
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC, IF_ID_valid, addr} !== {mw(16'h0000), 16'h0001, 1'b1, 16'h0001}) begin
      failures++;
      $display("[TB] FAIL latency_first: got ins=%h npc=%h v=%b addr=%h expected ins=%h npc=0001 v=1 addr=0001", IF_ID_ins, IF_ID_nextPC, IF_ID_valid, addr, mw(16'h0000));
    end
    step();
    checks++;
    if (IF_ID_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_bubble: got v=%b expected 0", IF_ID_valid);
    end
  endtask

  task automatic test_stall();
    lat_min = 0;
    lat_max = 0;
    do_reset();
    step();
    stall = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rd, IF_ID_ins, IF_ID_valid, PC} !== {1'b0, mw(16'h0000), 1'b1, 16'h0002}) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: got rd=%b ins=%h v=%b pc=%h expected rd=0 ins=%h v=1 pc=0002", k, rd, IF_ID_ins, IF_ID_valid, PC, mw(16'h0000));
      end
      if (k == 1) stall = 1'b0;
      step();
    end
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC, IF_ID_valid, rd, addr} !== {mw(16'h0001), 16'h0002, 1'b1, 1'b1, 16'h0002}) begin
      failures++;
      $display("[TB] FAIL stall_drain: got ins=%h npc=%h v=%b rd=%b addr=%h expected ins=%h npc=0002 v=1 rd=1 addr=0002", IF_ID_ins, IF_ID_nextPC, IF_ID_valid, rd, addr, mw(16'h0001));
    end
    step();
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC} !== {mw(16'h0002), 16'h0003}) begin
      failures++;
      $display("[TB] FAIL stall_resume: got ins=%h npc=%h expected ins=%h npc=0003", IF_ID_ins, IF_ID_nextPC, mw(16'h0002));
    end
  endtask

  task automatic test_redirect();
    lat_min = 0;
    lat_max = 0;
    do_reset();
    repeat (4) step();
    lat_min = 2;
    lat_max = 2;
    step();
    checks++;
    if ({rd, addr, rdy} !== {1'b1, 16'h0005, 1'b0}) begin
      failures++;
      $display("[TB] FAIL redirect_setup: got rd=%b addr=%h rdy=%b expected rd=1 addr=0005 rdy=0", rd, addr, rdy);
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    checks++;
    if ({rd, addr, PC, IF_ID_valid} !== {1'b1, 16'h0005, 16'h0040, 1'b0}) begin
      failures++;
      $display("[TB] FAIL redirect_drain: got rd=%b addr=%h pc=%h v=%b expected rd=1 addr=0005 pc=0040 v=0", rd, addr, PC, IF_ID_valid);
    end
    step();
    checks++;
    if ({rd, addr, rdy} !== {1'b1, 16'h0005, 1'b1}) begin
      failures++;
      $display("[TB] FAIL redirect_drain_ack: got rd=%b addr=%h rdy=%b expected rd=1 addr=0005 rdy=1", rd, addr, rdy);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rd, addr, IF_ID_valid} !== {1'b1, 16'h0040, 1'b0}) begin
        failures++;
        $display("[TB] FAIL redirect_refetch_%0d: got rd=%b addr=%h v=%b expected rd=1 addr=0040 v=0", k, rd, addr, IF_ID_valid);
      end
      step();
    end
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC, IF_ID_valid} !== {mw(16'h0040), 16'h0041, 1'b1}) begin
      failures++;
      $display("[TB] FAIL redirect_target: got ins=%h npc=%h v=%b expected ins=%h npc=0041 v=1", IF_ID_ins, IF_ID_nextPC, IF_ID_valid, mw(16'h0040));
    end
  endtask

  task automatic test_halt();
    lat_min = 1;
    lat_max = 1;
    do_reset();
    checks++;
    if ({rd, rdy} !== {1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL halt_setup: got rd=%b rdy=%b expected rd=1 rdy=0", rd, rdy);
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if ({rd, addr, rdy, is_halted, IF_ID_valid} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL halt_drain: got rd=%b addr=%h rdy=%b h=%b v=%b expected rd=1 addr=0000 rdy=1 h=0 v=0", rd, addr, rdy, is_halted, IF_ID_valid);
    end
    step();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({is_halted, rd, PC, IF_ID_valid} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
        failures++;
        $display("[TB] FAIL halted_%0d: got h=%b rd=%b pc=%h v=%b expected h=1 rd=0 pc=0000 v=0", k, is_halted, rd, PC, IF_ID_valid);
      end
      stall       = 1'($urandom_range(1, 0));
      redirect    = (k == 3);
      redirect_pc = 16'h1234;
      step();
    end
    stall    = 1'b0;
    redirect = 1'b0;

    lat_min = 0;
    lat_max = 0;
    do_reset();
    step();
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({is_halted, rd, PC, IF_ID_valid} !== {1'b1, 1'b0, 16'h0002, 1'b0}) begin
        failures++;
        $display("[TB] FAIL halt_direct_%0d: got h=%b rd=%b pc=%h v=%b expected h=1 rd=0 pc=0002 v=0", k, is_halted, rd, PC, IF_ID_valid);
      end
      step();
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({PC, is_halted} !== {RESET_PC, 1'b0}) begin
      failures++;
      $display("[TB] FAIL halt_reset: got pc=%h h=%b expected pc=%h h=0", PC, is_halted, RESET_PC);
    end
    reset_n = 1'b0;
  endtask

  task automatic test_wrap();
    lat_min = 0;
    lat_max = 0;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    checks++;
    if ({rd, addr, PC, IF_ID_valid} !== {1'b1, 16'hFFFF, 16'hFFFF, 1'b0}) begin
      failures++;
      $display("[TB] FAIL wrap_redirect: got rd=%b addr=%h pc=%h v=%b expected rd=1 addr=FFFF pc=FFFF v=0", rd, addr, PC, IF_ID_valid);
    end
    redirect    = 1'b1;
    halt        = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    halt     = 1'b0;
    checks++;
    if ({is_halted, PC, rd, addr, IF_ID_valid} !== {1'b0, 16'h0100, 1'b1, 16'h0100, 1'b0}) begin
      failures++;
      $display("[TB] FAIL redirect_beats_halt: got h=%b pc=%h rd=%b addr=%h v=%b expected h=0 pc=0100 rd=1 addr=0100 v=0", is_halted, PC, rd, addr, IF_ID_valid);
    end
    step();
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC, IF_ID_valid} !== {mw(16'h0100), 16'h0101, 1'b1}) begin
      failures++;
      $display("[TB] FAIL wrap_after_redirect: got ins=%h npc=%h v=%b expected ins=%h npc=0101 v=1", IF_ID_ins, IF_ID_nextPC, IF_ID_valid, mw(16'h0100));
    end
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC, IF_ID_valid, PC} !== {mw(16'hFFFF), 16'h0000, 1'b1, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL wrap_pc: got ins=%h npc=%h v=%b pc=%h expected ins=%h npc=0000 v=1 pc=0000", IF_ID_ins, IF_ID_nextPC, IF_ID_valid, PC, mw(16'hFFFF));
    end
    step();
    checks++;
    if ({IF_ID_ins, IF_ID_nextPC} !== {mw(16'h0000), 16'h0001}) begin
      failures++;
      $display("[TB] FAIL wrap_next: got ins=%h npc=%h expected ins=%h npc=0001", IF_ID_ins, IF_ID_nextPC, mw(16'h0000));
    end
  endtask

  task automatic test_random();
    int start;
    lat_min = 0;
    lat_max = 3;
    do_reset();
    start = delivered;
    repeat (400) begin
      stall       = ($urandom_range(9, 0) < 3);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = 16'($urandom);
      step();
    end
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (20) step();
    checks++;
    if (delivered - start < 40) begin
      failures++;
      $display("[TB] FAIL random_progress: got %0d instructions expected at least 40", delivered - start);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    delivered    = 0;
    reset_n      = 1'b1;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    halt         = 1'b0;
    lat_min      = 0;
    lat_max      = 0;
    exp_pc       = RESET_PC;
    exp_next     = RESET_PC;
    prev_addr    = '0;
    model_halted = 1'b0;
    prev_pending = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_cycle();
    test_latency();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that drives instruction memory port 1 and owns the architectural PC.
- Delivers the IF/ID pipeline register (instruction, PC+1, valid) to the decode/datapath stage.
- Handles variable-latency memory acknowledge, decode stalls, redirects (jump/branch flush) and halt.
- Includes a one-entry skid buffer so that an instruction acknowledged during a stall is never lost.

Parameters:
- WORD_SIZE, 16, data/address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, `NOP from opcodes.v, instruction word injected into IF/ID on flush or reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-high reset (asserted = 1, despite the suffix).
- readM1  out  1  instruction read request.
- address1  out  WORD_SIZE  fetch address. Held stable while readM1=1 and inputReady1=0.
- data1  in  WORD_SIZE  instruction data, valid when inputReady1=1.
- inputReady1  in  1  memory acknowledge for the current request; sampled only while readM1=1.
- stall  in  1  decode stage cannot accept a new IF/ID entry this cycle.
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  WORD_SIZE  redirect target.
- halt  in  1  HLT decoded; stop fetching.
- IF_ID_ins  out  WORD_SIZE  registered instruction.
- IF_ID_nextPC  out  WORD_SIZE  registered PC+1 of IF_ID_ins.
- IF_ID_valid  out  1  IF_ID_ins is a real instruction.
- PC  out  WORD_SIZE  address of the next instruction to fetch.
- is_halted  out  1  high in the HALTED state.

Behaviour:
- Reset (reset_n=1 at an edge):
  - PC=RESET_PC, IF_ID_ins=NOP_WORD, IF_ID_nextPC=0, IF_ID_valid=0.
  - Skid buffer empty, state=FETCH, is_halted=0.
  - Reset overrides all other inputs, including in the middle of a memory request. Memory must tolerate an abandoned request.
- States:
  - FETCH: readM1 = !buf_valid, address1=PC.
  - DRAIN: readM1=1, address1 = the held old address. Waits for an ack whose data is discarded.
  - HALT_DRAIN: same as DRAIN; goes to HALTED on ack.
  - HALTED: readM1=0. Exits only on reset.
- Event priority per cycle: reset > redirect > halt > stall > normal.
- Accept condition: an ack in FETCH (readM1 & inputReady1) always increments PC.
  - If stall=0 and the buffer is empty: IF_ID <= {data1, PC+1, valid=1}.
  - If stall=1: buffer <= {data1, PC+1} and buf_valid=1. IF_ID is held.
- Stall with no accept: IF_ID and PC held; readM1 stays asserted on the same address (allowed).
- Buffer drain: when stall=0 and buf_valid=1, IF_ID <= buffer, buf_valid <= 0, and a new request issues the next cycle. Throughput is one instruction per cycle with single-cycle memory.
- Bubble: when stall=0 and there is no accept and no buffer, IF_ID_valid <= 0 and IF_ID_ins <= NOP_WORD.
- Redirect:
  - IF_ID <= {NOP_WORD, 0, valid=0}, buffer cleared, PC <= redirect_pc.
  - If a request is outstanding and not acked this cycle, go to DRAIN, hold address1, discard the returned data, then return to FETCH at redirect_pc.
  - If the ack coincides with the redirect, discard data1 and stay in FETCH.
  - Redirect overrides stall.
- Halt (no redirect):
  - No new requests are issued. IF_ID is flushed to NOP with valid=0.
  - An outstanding unacked request goes to HALT_DRAIN; otherwise go straight to HALTED. PC is frozen.
  - halt and redirect in the same cycle: the redirect wins and halt is ignored, because the redirecting instruction is older.
- Arithmetic: PC+1 is modulo 2^WORD_SIZE (FFFF wraps to 0000). No alignment checks.
- All outputs are registered except readM1 and address1, which are decoded combinationally from the state, PC and the held address.

Test Plan:
- Single-cycle memory (inputReady1 tied 1), reset then release, mem[0..2]=A1,A2,A3 -> IF_ID_ins A1, A2, A3 on consecutive cycles; nextPC 1, 2, 3; PC=3 after the third.
- 3-cycle memory latency -> address1=0 held for 3 cycles; IF_ID_valid=0 bubbles in between; A1 appears on the cycle after the ack.
- stall=1 for 2 cycles while A2 is acked -> IF_ID holds A1, buffer holds A2, readM1=0. stall=0 -> A2 in IF_ID the next cycle, no instruction lost or duplicated.
- Redirect to 16'h0040 while the request to 16'h0005 is outstanding (ack 2 cycles later) -> DRAIN; address1 stays 0005; its data is discarded; the next request is 0040; IF_ID_valid=0 until mem[0040] arrives.
- halt while a request is outstanding, then the ack -> HALTED; is_halted=1; readM1=0 forever; PC frozen; reset_n=1 returns PC to RESET_PC and clears is_halted.
- PC=16'hFFFF fetch with redirect and halt asserted together -> the redirect is taken and is_halted stays 0. A separate fetch at FFFF with no redirect gives IF_ID_nextPC=0000 and PC wraps to 0000.
